// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

    // Width of the single ripple-carry slice reused on every step.
    localparam int NIBBLE_W = 4;

    // Sequencer states. The encodings are fixed so the state register can be probed in the lab.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage : nibble_serial_adder_ctrl_pkg

// File: rtl/nibble_adder_slice.sv
// Purely combinational 4-bit ripple-carry adder.
// c[i] is the carry out of bit i. c[3] is the carry out of the nibble, and
// c[2] is the carry into its top bit.
module nibble_adder_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic [NIBBLE_W-1:0] c
);

    // w_carry[i] is the carry into bit i. w_carry[0] is the slice carry-in.
    logic [NIBBLE_W:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
    end

    assign c = w_carry[NIBBLE_W:1];

endmodule : nibble_adder_slice

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands through one 4-bit slice, least-significant nibble first.
// The carry between nibbles is held in a register.
// The block uses a start/busy/done handshake. sum, cout and ovf hold the last completed result.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_partial;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [NIBBLE_W-1:0] w_s;
    logic [NIBBLE_W-1:0] w_c;
    logic [WIDTH-1:0]    w_partial_next;
    logic                w_unused_low_carries;

    // The slice always works on the low nibbles of the operand shift registers.
    nibble_adder_slice u_slice (
        .a   (r_op_a[NIBBLE_W-1:0]),
        .b   (r_op_b[NIBBLE_W-1:0]),
        .cin (r_carry),
        .s   (w_s),
        .c   (w_c)
    );

    // Each new slice sum enters at the top of the partial register.
    // After NIB steps, nibble 0 has reached the bottom.
    assign w_partial_next = {w_s, r_partial[WIDTH-1:NIBBLE_W]};

    // Only the two top per-bit carries matter at this level.
    assign w_unused_low_carries = ^w_c[1:0];

    // The sequencer FSM, the operand and carry datapath, and the result registers.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            // NOTE: the operand and partial registers are cleared with the rest.
            // This stops an aborted run from leaving stale data that is visible in simulation.
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_partial <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_op_a    <= r_op_a >> NIBBLE_W;
                    r_op_b    <= r_op_b >> NIBBLE_W;
                    r_carry   <= w_c[NIBBLE_W-1];
                    r_partial <= w_partial_next;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_NIB) begin
                        r_sum   <= w_partial_next;
                        r_cout  <= w_c[NIBBLE_W-1];
                        r_ovf   <= w_c[NIBBLE_W-1] ^ w_c[NIBBLE_W-2];
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// The reference result is plain wide arithmetic.
// Signed overflow is judged from the operand and result signs.
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    // Model of the held result outputs.
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge. Inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_busy, input logic exp_done);
        check({tag, "/busy"}, WIDTH'(busy), WIDTH'(exp_busy));
        check({tag, "/done"}, WIDTH'(done), WIDTH'(exp_done));
        check({tag, "/sum"},  sum,          exp_sum);
        check({tag, "/cout"}, WIDTH'(cout), WIDTH'(exp_cout));
        check({tag, "/ovf"},  WIDTH'(ovf),  WIDTH'(exp_ovf));
    endtask

    // Reference addition: unsigned sum with carry-out, plus a sign-based signed overflow.
    task automatic model_add(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mc,
                             output logic [WIDTH-1:0] ms, output logic mco, output logic mov);
        int unsigned full;
        full = int'(ma) + int'(mb) + int'(mc);
        ms   = full[WIDTH-1:0];
        mco  = full[WIDTH];
        mov  = (ma[WIDTH-1] == mb[WIDTH-1]) && (ms[WIDTH-1] != ma[WIDTH-1]);
    endtask

    // One full transaction starting from IDLE.
    // Inputs and start are scrambled during RUN and DONE, and both must be ignored.
    task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op,
                           input logic tc, input string tag);
        logic [WIDTH-1:0] ns;
        logic             nco;
        logic             nov;
        model_add(ta, tb_op, tc, ns, nco, nov);
        a = ta; b = tb_op; cin = tc; start = 1'b1;
        tick();
        for (int i = 1; i <= NIB; i++) begin
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            cin   = 1'($urandom);
            start = 1'($urandom);
            check_outputs($sformatf("%s/run%0d", tag, i), 1'b1, 1'b0);
            tick();
        end
        exp_sum = ns; exp_cout = nco; exp_ovf = nov;
        check_outputs({tag, "/done"}, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        check_outputs({tag, "/idle"}, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        tick();
        tick();
        check_outputs("reset", 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_outputs("post_reset_idle", 1'b0, 1'b0);

        // Directed cases.
        run_add(16'h1234, 16'h4321, 1'b0, "basic");
        run_add(16'hFFFF, 16'h0001, 1'b0, "carry_chain");
        run_add(16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
        run_add(16'h8000, 16'h8000, 1'b1, "neg_ovf_cin");
        run_add(16'h0000, 16'h0000, 1'b1, "cin_only");
        run_add(16'hFFFF, 16'hFFFF, 1'b1, "all_ones");

        // With start held high, the second request is accepted in the IDLE cycle after DONE.
        // That gives one addition per NIB+2 cycles.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        tick();
        a = 16'h0F0F; b = 16'h0101;
        for (int i = 1; i <= NIB; i++) begin
            check_outputs($sformatf("held1/run%0d", i), 1'b1, 1'b0);
            tick();
        end
        exp_sum = 16'h3333; exp_cout = 1'b0; exp_ovf = 1'b0;
        check_outputs("held1/done", 1'b0, 1'b1);
        tick();
        check_outputs("held/idle_gap", 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= NIB; i++) begin
            check_outputs($sformatf("held2/run%0d", i), 1'b1, 1'b0);
            if (i == 1) start = 1'b0;
            tick();
        end
        exp_sum = 16'h1010; exp_cout = 1'b0; exp_ovf = 1'b0;
        check_outputs("held2/done", 1'b0, 1'b1);
        tick();
        check_outputs("held2/idle", 1'b0, 1'b0);

        // Reset mid-run aborts the operation with no done pulse, and the outputs clear.
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        check_outputs("abort", 1'b0, 1'b0);
        for (int i = 0; i < NIB + 2; i++) begin
            tick();
            check_outputs($sformatf("abort/quiet%0d", i), 1'b0, 1'b0);
        end
        run_add(16'hAAAA, 16'h5555, 1'b0, "after_abort");

        // Random operands.
        for (int n = 0; n < 24; n++) begin
            run_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serial_adder_ctrl
